// File: rtl/sorter_arbiter.sv
// sorter_arbiter: round-robin sharing of one 4-entry sorter among NUM_REQ frame sources (SORTER_ARB_FRAME_CHECK_EN adds sof/eof frame checking)
module sorter_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_REQ      = 4,
    parameter int ID_WIDTH     = 2,
    parameter int DONE_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ-1:0]            req_sof,
    input  logic [NUM_REQ-1:0]            req_eof,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [DATA_WIDTH-1:0]         srt_din,
    output logic                          srt_vld,
    output logic                          srt_sof,
    output logic                          srt_eof,
    input  logic [DATA_WIDTH-1:0]         srt_lvl1,
    input  logic [DATA_WIDTH-1:0]         srt_lvl2,
    input  logic [DATA_WIDTH-1:0]         srt_lvl3,
    input  logic [DATA_WIDTH-1:0]         srt_lvl4,
    input  logic                          srt_done,
    output logic [DATA_WIDTH-1:0]         res_lvl1,
    output logic [DATA_WIDTH-1:0]         res_lvl2,
    output logic [DATA_WIDTH-1:0]         res_lvl3,
    output logic [DATA_WIDTH-1:0]         res_lvl4,
    output logic [ID_WIDTH-1:0]           res_id,
    output logic                          res_err,
    output logic                          res_vld,
    input  logic                          res_rdy,
    output logic                          busy
);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, FEED, WAIT, RESULT} state_t;
    state_t state, state_nxt;
    logic [ID_WIDTH-1:0] ptr, grant_id, cand_id;
    logic cand_hit, accept, timeout, g_vld, g_sof, g_eof, frm_err;
    logic [DATA_WIDTH-1:0] g_din;
    logic [1:0] beat;
    logic [TW-1:0] tcnt;
    int best_d;

    assign accept  = state == FEED && g_vld;
    assign timeout = tcnt + TW'(1) == TW'(DONE_TIMEOUT);
    assign busy    = state != IDLE;

    // pick the sof-valid requester closest at or after the round-robin pointer
    always_comb begin
        cand_hit = 1'b0;
        cand_id  = '0;
        best_d   = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_vld[i] && req_sof[i] && (i + NUM_REQ - int'(ptr)) % NUM_REQ < best_d) begin
                cand_hit = 1'b1;
                cand_id  = ID_WIDTH'(i);
                best_d   = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
            end
        end
    end

    // select the granted requester's beat and open only its ready while feeding
    always_comb begin
        g_din   = '0;
        g_vld   = 1'b0;
        g_sof   = 1'b0;
        g_eof   = 1'b0;
        req_rdy = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                g_din      = req_din[i*DATA_WIDTH +: DATA_WIDTH];
                g_vld      = req_vld[i];
                g_sof      = req_sof[i];
                g_eof      = req_eof[i];
                req_rdy[i] = state == FEED;
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next-state: grant, four accepted beats, sorter done or timeout, result handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = cand_hit ? FEED : IDLE;
            FEED:    state_nxt = accept && beat == 2'd3 ? WAIT : FEED;
            WAIT:    state_nxt = srt_done || timeout ? RESULT : WAIT;
            RESULT:  state_nxt = res_rdy ? IDLE : RESULT;
            default: state_nxt = IDLE;
        endcase
    end

    // grant bookkeeping, beat/timeout counters and the registered sorter feed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            grant_id <= '0;
            beat     <= '0;
            tcnt     <= '0;
            srt_din  <= '0;
            srt_vld  <= 1'b0;
            srt_sof  <= 1'b0;
            srt_eof  <= 1'b0;
        end else begin
            if (state == IDLE && cand_hit) begin
                grant_id <= cand_id;
                ptr      <= cand_id == ID_WIDTH'(NUM_REQ - 1) ? '0 : cand_id + 1'b1;
            end
            if (accept) begin
                srt_din <= g_din;
                beat    <= beat + 2'd1;
            end
            srt_vld <= accept;
            srt_sof <= accept && beat == 2'd0;
            srt_eof <= accept && beat == 2'd3;
            tcnt    <= state == WAIT ? tcnt + 1'b1 : '0;
        end
    end

    // latch the sorter output on done or timeout and hold it until consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_lvl1 <= '0;
            res_lvl2 <= '0;
            res_lvl3 <= '0;
            res_lvl4 <= '0;
            res_id   <= '0;
            res_err  <= 1'b0;
            res_vld  <= 1'b0;
        end else if (state == WAIT && state_nxt == RESULT) begin
            res_lvl1 <= srt_lvl1;
            res_lvl2 <= srt_lvl2;
            res_lvl3 <= srt_lvl3;
            res_lvl4 <= srt_lvl4;
            res_id   <= grant_id;
            res_err  <= !srt_done || frm_err;
            res_vld  <= 1'b1;
        end else if (state == RESULT && res_rdy) begin
            res_vld <= 1'b0;
        end
    end

`ifdef SORTER_ARB_FRAME_CHECK_EN
    // flag any accepted beat whose sof/eof disagrees with its position in the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) frm_err <= 1'b0;
        else if (state == IDLE && cand_hit) frm_err <= 1'b0;
        else if (accept && (g_sof != (beat == 2'd0) || g_eof != (beat == 2'd3))) frm_err <= 1'b1;
    end
`else
    logic frm_unused;
    assign frm_unused = g_sof ^ g_eof;
    assign frm_err    = 1'b0;
`endif
endmodule

// File: doc/sorter_arbiter.md
Name: sorter_arbiter

Overview:
- Shares one 4-entry sorter instance between NUM_REQ frame sources.
- Round-robin grants a requester, feeds its 4-word frame into the sorter, waits for the sorter's done pulse, then returns the sorted result tagged with the requester id over a valid/ready result port.
- Sits between the stream sources and the sorter datapath; it is the only driver of the sorter inputs.

Parameters:
- DATA_WIDTH, 16, word width; must match the sorter.
- NUM_REQ, 4, number of requesters, 2..8.
- ID_WIDTH, 2, width of res_id; must be at least clog2(NUM_REQ).
- DONE_TIMEOUT, 15, max cycles spent in WAIT before aborting the frame with an error.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_din  in  NUM_REQ*DATA_WIDTH  requester i data in slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_vld  in  NUM_REQ  per-requester beat valid.
- req_sof  in  NUM_REQ  per-requester start of frame.
- req_eof  in  NUM_REQ  per-requester end of frame.
- req_rdy  out  NUM_REQ  per-requester beat ready.
- srt_din  out  DATA_WIDTH  sorter data, registered.
- srt_vld  out  1  sorter valid, registered.
- srt_sof  out  1  sorter start of frame, registered.
- srt_eof  out  1  sorter end of frame, registered.
- srt_lvl1..srt_lvl4  in  DATA_WIDTH each  sorter outputs, largest first.
- srt_done  in  1  sorter one-cycle done pulse.
- res_lvl1..res_lvl4  out  DATA_WIDTH each  latched sorted result.
- res_id  out  ID_WIDTH  index of the requester that owns the result.
- res_err  out  1  result invalid: timeout, or frame error when the optional feature is compiled in.
- res_vld  out  1  result valid.
- res_rdy  in  1  result consumer ready.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, rr pointer=0, grant_id=0, beat count=0, timeout count=0.
  - All outputs 0, including srt_*, res_*, req_rdy and busy.
  - The sorter must share the same rst net.
- States:
  - IDLE:
    - Candidates are requesters i with req_vld[i]&&req_sof[i].
    - Grant the first candidate at or after the rr pointer, wrapping.
    - Register grant_id, set pointer <= (grant_id+1) mod NUM_REQ, go to FEED.
    - No candidate: stay in IDLE.
    - The candidate's sof beat is not consumed in IDLE.
  - FEED:
    - req_rdy[grant_id]=1; all other req_rdy bits 0.
    - A beat is accepted when req_vld[grant_id]&&req_rdy[grant_id].
    - On accept, next cycle: srt_din=data, srt_vld=1, srt_sof=(beat==0), srt_eof=(beat==3). srt_sof and srt_eof are generated by the arbiter, not passed through.
    - Cycles with no accept: srt_vld=0 and srt_sof=srt_eof=0.
    - After the 4th accept (beat==3), go to WAIT with timeout count=0.
    - req_vld low mid-frame stalls FEED indefinitely; no timeout applies in FEED.
  - WAIT:
    - req_rdy all 0.
    - srt_done=1: latch srt_lvl1..4 into res_lvl1..4, set res_err=0, go to RESULT.
    - Otherwise increment the timeout count. When it reaches DONE_TIMEOUT, go to RESULT with res_err=1 and latch the current srt_lvl values.
    - Nominal latency: done is seen 2 cycles after the 4th accept edge (1 cycle for the srt_* register, 1 cycle for the sorter).
  - RESULT:
    - res_vld=1 and res_id=grant_id; res_* held stable while res_rdy=0.
    - res_vld&&res_rdy: clear res_vld, go to IDLE.
    - A new grant can happen in the cycle after the handshake.
- Fairness:
  - A requester that was just served has lowest priority in the next arbitration.
  - With all requesters continuously ready, grants cycle 0,1,..,NUM_REQ-1,0,...
- Boundary conditions:
  - srt_done outside WAIT is ignored.
  - sof/eof on non-granted requesters is ignored.
  - Reset asserted mid-frame aborts immediately; no result is emitted for the aborted frame.
  - res_rdy tied high gives a one-cycle res_vld pulse.

Optional Feature:
- Macro: SORTER_ARB_FRAME_CHECK_EN.
- Defined:
  - In FEED, an error flag latches if any of these holds:
    - sof=0 on beat 0;
    - sof=1 on beats 1-3;
    - eof=1 on beats 0-2;
    - eof=0 on beat 3.
  - res_err = flag OR timeout. The flag clears on entry to FEED.
  - The frame is still fed to the sorter for exactly 4 beats.
- Undefined: req_sof/req_eof are ignored after the grant, and res_err reflects timeout only.

Test Plan:
- Single frame, req 0, beats 5,9,2,7 back-to-back, res_rdy=1 -> srt_vld high 4 cycles with sof on beat 0 and eof on beat 3; res_lvl=9,7,5,2, res_id=0, res_err=0, res_vld exactly 1 cycle.
- All 4 requesters hold frames continuously -> grant order 0,1,2,3,0; each result matches its own data; no beat from a non-granted requester reaches srt_din.
- req 2 drops req_vld for 3 cycles after beat 1 -> FEED stalls, srt_vld=0 during the gap, result still correct; 3,3,3,3 -> res_lvl=3,3,3,3.
- srt_done forced low (sorter stubbed) -> RESULT entered exactly DONE_TIMEOUT=15 cycles after WAIT entry, res_err=1.
- res_rdy held low 10 cycles -> res_vld and res_* stable, no new grant; grant issued the cycle after the handshake.
- Async rst pulse during beat 2 -> all outputs 0 immediately, no result emitted. With SORTER_ARB_FRAME_CHECK_EN, eof on beat 1 -> res_err=1.
